program_loader: RTL

- Boot-time loader directly upstream of the CPU's instruction memory.
- Receives a program as a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes each word into instruction memory at sequential word addresses and verifies a trailing checksum byte.
- Holds the CPU in reset (cpu_hold) until a load completes successfully. This replaces the simulation-only memory file preload with a synthesizable path.

---
 rtl/program_loader.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// Boot-time program loader. Takes a byte stream over a valid/ready handshake
// and packs it into big-endian 32-bit words. Each word is written to
// sequential instruction-memory addresses. A trailing checksum byte is then
// verified. The CPU is held in reset until a load completes with a good
// checksum.
module program_loader #(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic [7:0]            byte_data,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  imem_write_enable,
    output logic [ADDR_WIDTH-1:0] imem_address,
    output logic [31:0]           imem_write_data,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    // Largest program that fits the memory: 2^ADDR_WIDTH words.
    localparam logic [ADDR_WIDTH:0] MaxWords = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [2:0] {
        StIdle,
        StReceive,
        StWrite,
        StCheck,
        StDone,
        StError
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH:0]   written_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           data_q;
    logic [1:0]            byte_idx_q;
    logic [7:0]            sum_q;

    logic                  accept;
    logic                  start_seen;
    logic                  count_zero;
    logic                  count_big;
    logic                  load_begin;
    logic [7:0]            sum_next;
    logic [ADDR_WIDTH:0]   written_inc;

    assign accept      = byte_valid && byte_ready;
    // start only matters in the resting states; it is ignored mid-load.
    assign start_seen  = start && (state_q == StIdle || state_q == StDone || state_q == StError);
    assign count_zero  = (word_count == '0);
    assign count_big   = (word_count > MaxWords);
    assign load_begin  = start_seen && !count_zero && !count_big;
    assign sum_next    = sum_q + byte_data;
    assign written_inc = written_q + (ADDR_WIDTH + 1)'(1);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone, StError: begin
                if (start_seen) begin
                    if (count_zero) begin
                        state_d = StDone;
                    end else if (count_big) begin
                        state_d = StError;
                    end else begin
                        state_d = StReceive;
                    end
                end
            end
            StReceive: begin
                if (accept && byte_idx_q == 2'd3) begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                state_d = (written_inc == count_q) ? StCheck : StReceive;
            end
            StCheck: begin
                if (accept) begin
                    state_d = (sum_next == 8'h00) ? StDone : StError;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath: word assembly, running sum, address and word counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q    <= '0;
            written_q  <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            byte_idx_q <= '0;
            sum_q      <= '0;
        end else begin
            if (load_begin) begin
                count_q    <= word_count;
                written_q  <= '0;
                addr_q     <= '0;
                byte_idx_q <= '0;
                sum_q      <= '0;
            end
            if (state_q == StReceive && accept) begin
                // First byte of each word lands in the MSB.
                unique case (byte_idx_q)
                    2'd0: data_q[31:24] <= byte_data;
                    2'd1: data_q[23:16] <= byte_data;
                    2'd2: data_q[15:8]  <= byte_data;
                    2'd3: data_q[7:0]   <= byte_data;
                endcase
                byte_idx_q <= byte_idx_q + 2'd1;
                sum_q      <= sum_next;
            end
            if (state_q == StWrite) begin
                written_q <= written_inc;
                // Only advance when another word follows, so the address never wraps.
                if (written_inc != count_q) begin
                    addr_q <= addr_q + ADDR_WIDTH'(1);
                end
            end
        end
    end

    // Outputs decoded from state.
    always_comb begin
        byte_ready        = 1'b0;
        imem_write_enable = 1'b0;
        done              = 1'b0;
        error             = 1'b0;
        cpu_hold          = 1'b1;
        unique case (state_q)
            StReceive, StCheck: byte_ready = 1'b1;
            StWrite:            imem_write_enable = 1'b1;
            StDone: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
            end
            StError:            error = 1'b1;
            default: ;
        endcase
    end

    assign imem_address    = addr_q;
    assign imem_write_data = data_q;

endmodule
